// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Each accepted request runs IDLE -> EXEC -> RESP and is returned on a valid/ready response port.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*32-1:0] req_rs1_i,
    input  logic [NUM_REQ*32-1:0] req_rs2_i,
    input  logic [NUM_REQ*4-1:0]  req_op_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [ID_W-1:0]       rsp_id_o,
    output logic [31:0]           rsp_result_o,
    output logic                  rsp_zero_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   op_id_q, op_id_d;
    logic [31:0]       op_rs1_q, op_rs1_d;
    logic [31:0]       op_rs2_q, op_rs2_d;
    logic [3:0]        op_code_q, op_code_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [31:0]       rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [31:0]       alu_result;

    function automatic logic [31:0] aluCompute(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic [3:0]  op);
        logic [31:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << b[4:0];
            4'd6:    r = a >> b[4:0];
            4'd7:    r = {31'd0, $signed(a) < $signed(b)};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Search starts at rr_ptr and wraps, so the most recently served requester is tried last.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = '0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!grant_found && req_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign alu_result = aluCompute(op_rs1_q, op_rs2_q, op_code_q);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_id_d      = op_id_q;
        op_rs1_d     = op_rs1_q;
        op_rs2_d     = op_rs2_q;
        op_code_d    = op_code_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        req_ready_o  = '0;
        case (state_q)
            IDLE: begin
                // Ready is withheld during reset so nothing is accepted that reset would discard.
                if (grant_found && !rst_i) begin
                    req_ready_o[grant_id] = 1'b1;
                    op_id_d   = grant_id;
                    op_rs1_d  = req_rs1_i[32*grant_id +: 32];
                    op_rs2_d  = req_rs2_i[32*grant_id +: 32];
                    op_code_d = req_op_i[4*grant_id +: 4];
                    rr_ptr_d  = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_zero_d   = (alu_result == 32'd0);
                rsp_id_d     = op_id_q;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            op_id_q      <= '0;
            op_rs1_q     <= '0;
            op_rs2_q     <= '0;
            op_code_q    <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_id_q      <= op_id_d;
            op_rs1_q     <= op_rs1_d;
            op_rs2_q     <= op_rs2_d;
            op_code_q    <= op_code_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign rsp_valid_o  = (state_q == RESP) && !rst_i;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zero_o   = rsp_zero_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios followed by randomized traffic,
// checked against a round-robin/ALU reference model kept in the bench.
module tb_alu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] result;
        logic        zero;
        int          accCycle;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    reqValid;
    logic [NUM_REQ-1:0]    reqReady;
    logic [31:0]           rs1 [NUM_REQ];
    logic [31:0]           rs2 [NUM_REQ];
    logic [3:0]            opc [NUM_REQ];
    logic [NUM_REQ*32-1:0] rs1Bus;
    logic [NUM_REQ*32-1:0] rs2Bus;
    logic [NUM_REQ*4-1:0]  opBus;
    logic                  rspValid;
    logic                  rspReady;
    logic [ID_W-1:0]       rspId;
    logic [31:0]           rspResult;
    logic                  rspZero;
    logic                  busy;

    int   checks;
    int   failures;
    int   cycle;
    int   acceptTotal;
    int   accCount [NUM_REQ];
    int   seenAcc [NUM_REQ];
    int   modelPtr;
    logic outstanding;
    logic prevRst;
    exp_t sb [$];

    alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_rs1_i    (rs1Bus),
        .req_rs2_i    (rs2Bus),
        .req_op_i     (opBus),
        .rsp_valid_o  (rspValid),
        .rsp_ready_i  (rspReady),
        .rsp_id_o     (rspId),
        .rsp_result_o (rspResult),
        .rsp_zero_o   (rspZero),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rs1Bus = '0;
        rs2Bus = '0;
        opBus  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rs1Bus[32*i +: 32] = rs1[i];
            rs2Bus[32*i +: 32] = rs2[i];
            opBus[4*i +: 4]    = opc[i];
        end
    end

    function automatic logic [31:0] refAlu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a * (32'd1 << sh);
            4'd6:    return a / (32'd1 << sh);
            4'd7:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int refPick(input logic [NUM_REQ-1:0] v, input int ptr);
        logic [NUM_REQ-1:0] t;
        for (int k = 0; k < NUM_REQ; k++) begin
            t = v >> ((ptr + k) % NUM_REQ);
            if (t[0]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    // Monitor: predicts grants from the reference model and retires responses from the scoreboard.
    task monitorLoop;
        int                 pick;
        logic [1:0]         pid;
        logic [NUM_REQ-1:0] expReady;
        exp_t               e;
        forever begin
            @(negedge clk);
            cycle++;
            if (rst) begin
                checkOutput("rst_req_ready", 64'(reqReady), 64'd0);
                checkOutput("rst_rsp_valid", 64'(rspValid), 64'd0);
                if (prevRst) begin
                    checkOutput("rst_state", 64'({busy, rspZero, rspId, rspResult}), 64'd0);
                end
                outstanding = 1'b0;
                sb.delete();
                modelPtr = 0;
                prevRst  = 1'b1;
            end else begin
                prevRst  = 1'b0;
                pick     = refPick(reqValid, modelPtr);
                expReady = '0;
                if (!outstanding && pick >= 0) expReady = NUM_REQ'(1) << pick;
                checkOutput("req_ready", 64'(reqReady), 64'(expReady));
                checkOutput("busy", 64'(busy), 64'(outstanding));
                if (expReady != '0) begin
                    pid        = 2'(pick);
                    e.id       = pid;
                    e.result   = refAlu(rs1[pid], rs2[pid], opc[pid]);
                    e.zero     = (e.result == 32'd0);
                    e.accCycle = cycle;
                    sb.push_back(e);
                    outstanding = 1'b1;
                    modelPtr    = (pick + 1) % NUM_REQ;
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (reqValid[i] && reqReady[i]) begin
                        accCount[i]++;
                        acceptTotal++;
                    end
                end
                if (sb.size() > 0) begin
                    checkOutput("rsp_valid_timing", 64'(rspValid),
                                64'(cycle >= sb[0].accCycle + 2));
                    if (rspValid) begin
                        checkOutput("rsp_id", 64'(rspId), 64'(sb[0].id));
                        checkOutput("rsp_result", 64'(rspResult), 64'(sb[0].result));
                        checkOutput("rsp_zero", 64'(rspZero), 64'(sb[0].zero));
                        if (rspReady) begin
                            void'(sb.pop_front());
                            outstanding = 1'b0;
                        end
                    end
                end else begin
                    checkOutput("rsp_valid_idle", 64'(rspValid), 64'd0);
                end
            end
        end
    endtask

    task automatic stepCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
        rs1[i]      = a;
        rs2[i]      = b;
        opc[i]      = op;
        reqValid[i] = 1'b1;
    endtask

    task automatic applyStimulus(input int i);
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = $urandom_range(0, 40);
            default: b = $urandom;
        endcase
        op = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 8));
        setReq(i, a, b, op);
    endtask

    task automatic waitAccepts(input int n, input int budget);
        int target;
        int k;
        target = acceptTotal + n;
        k = 0;
        while (acceptTotal < target && k < budget) begin
            stepCycle();
            k++;
        end
        checkOutput("wait_accept", 64'(acceptTotal >= target), 64'd1);
    endtask

    task automatic waitIdle(input int budget);
        int k;
        k = 0;
        while ((outstanding || sb.size() > 0) && k < budget) begin
            stepCycle();
            k++;
        end
        checkOutput("wait_idle", 64'(outstanding), 64'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        cycle       = 0;
        acceptTotal = 0;
        modelPtr    = 0;
        outstanding = 1'b0;
        prevRst     = 1'b0;
        rst         = 1'b1;
        rspReady    = 1'b1;
        reqValid    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            accCount[i] = 0;
            seenAcc[i]  = 0;
            rs1[i]      = '0;
            rs2[i]      = '0;
            opc[i]      = '0;
        end
        fork
            monitorLoop();
        join_none

        // Reset with every requester asking, then continuous SUB i-i from all four.
        for (int i = 0; i < NUM_REQ; i++) setReq(i, 32'(i), 32'(i), 4'd1);
        repeat (3) stepCycle();
        rst = 1'b0;
        waitAccepts(5, 40);
        reqValid = '0;
        waitIdle(10);

        setReq(1, 32'd5, 32'd7, 4'd0);
        waitAccepts(1, 10);
        reqValid = '0;
        waitIdle(10);

        // Stalled SLT response while another requester waits for a grant.
        rspReady = 1'b0;
        setReq(2, 32'hFFFF_FFFF, 32'd1, 4'd7);
        waitAccepts(1, 10);
        reqValid[2] = 1'b0;
        setReq(0, 32'd3, 32'd4, 4'd0);
        repeat (10) stepCycle();
        rspReady = 1'b1;
        waitAccepts(1, 10);
        reqValid = '0;
        waitIdle(10);

        setReq(3, 32'd1, 32'h0000_0021, 4'd5);
        waitAccepts(1, 10);
        reqValid = '0;
        waitIdle(10);
        setReq(3, 32'h1234_5678, 32'd9, 4'hF);
        waitAccepts(1, 10);
        reqValid = '0;
        waitIdle(10);

        // Reset while in EXEC, then while in RESP; the following grant must restart at requester 0.
        setReq(1, 32'd10, 32'd20, 4'd0);
        waitAccepts(1, 10);
        rst      = 1'b1;
        reqValid = '0;
        stepCycle();
        rst = 1'b0;
        stepCycle();
        rspReady = 1'b0;
        setReq(1, 32'd10, 32'd20, 4'd0);
        waitAccepts(1, 10);
        reqValid = '0;
        stepCycle();
        rst = 1'b1;
        stepCycle();
        rst      = 1'b0;
        rspReady = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) setReq(i, 32'(i + 1), 32'd2, 4'd3);
        waitAccepts(1, 10);
        reqValid = '0;
        waitIdle(10);

        for (int i = 0; i < NUM_REQ; i++) seenAcc[i] = accCount[i];
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accCount[i] != seenAcc[i]) begin
                    seenAcc[i] = accCount[i];
                    if ($urandom_range(0, 3) != 0) applyStimulus(i);
                    else reqValid[i] = 1'b0;
                end else if (!reqValid[i] && $urandom_range(0, 2) == 0) begin
                    applyStimulus(i);
                end
            end
            rspReady = ($urandom_range(0, 3) != 0);
            stepCycle();
        end
        reqValid = '0;
        rspReady = 1'b1;
        waitIdle(20);
        stepCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
